arm_mc_controller: RTL and testbench

//  Multicycle ARM control unit: a Moore FSM plus condition logic that drives a

---
 rtl/arm_mc_controller.sv | 255 +++++++++++++++++++++++++
 tb/tb_arm_mc_controller.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: Moore FSM, condition check and flag register
// driving a shared-memory multicycle datapath, with memory wait states and a
// wait-state timeout that parks the FSM in FAULT.
//
// Inputs : clk, reset (async, active-low), Instr (Instr[31:12]),
//          ALUFlags {N,Z,C,V}, mem_ready
// Outputs: mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
//          ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc,
//          state_dbg, timeout_err (sticky), illegal_op (DECODE pulse)
module arm_mc_controller #(
    parameter int unsigned MEM_WAIT_EN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  state_dbg,
    output logic        timeout_err,
    output logic        illegal_op
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_FAULT    = 4'd15;

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    logic [3:0]       state_q, state_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;

    logic rdy;
    logic mem_st;
    logic timeout;
    logic cond_ex;
    logic rd_pc;
    logic [1:0] alu_op;

    assign rdy    = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
    assign mem_st = (state_q == S_FETCH) || (state_q == S_MEMREAD)
                 || (state_q == S_MEMWRITE);
    // the wait that would be the TIMEOUT_CYCLES-th in a row goes to FAULT
    assign timeout = TO_EN && mem_st && !rdy && (cnt_q == CNT_LAST);
    assign rd_pc  = (rd == 4'd15);

    logic n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = !z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = !c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = !n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = !v_f;
            4'b1000: cond_ex = c_f && !z_f;
            4'b1001: cond_ex = !c_f || z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = !z_f && (n_f == v_f);
            4'b1101: cond_ex = z_f || (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        alu_op = 2'b00;
        case (funct[4:1])
            4'b0100: alu_op = 2'b00;
            4'b0010: alu_op = 2'b01;
            4'b0000: alu_op = 2'b10;
            4'b1100: alu_op = 2'b11;
            default: alu_op = 2'b00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (rdy) state_d = S_MEMWB;
            S_MEMWRITE: if (rdy) state_d = S_FETCH;
            S_EXECR,
            S_EXECI:    state_d = S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BRANCH:   state_d = S_FETCH;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_FETCH;
        endcase
        if (timeout) state_d = S_FAULT;
    end

    always_comb begin
        cnt_d = '0;
        if (mem_st && !rdy) cnt_d = cnt_q + 1'b1;
    end

    assign terr_d = terr_q || timeout;

    // NZ follow every S-bit op; CV only when the ALU ran ADD or SUB
    always_comb begin
        flags_d = flags_q;
        if ((state_q == S_EXECR || state_q == S_EXECI)
            && funct[0] && cond_ex) begin
            flags_d[3:2] = ALUFlags[3:2];
            if (alu_op == 2'b00 || alu_op == 2'b01)
                flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    logic mreq, pc_w, ir_w, rg_w, mw;

    always_comb begin
        mreq       = 1'b0;
        pc_w       = 1'b0;
        ir_w       = 1'b0;
        rg_w       = 1'b0;
        mw         = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        case (state_q)
            S_FETCH: begin
                mreq      = 1'b1;
                ir_w      = rdy;
                pc_w      = rdy;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                mreq   = 1'b1;
                AdrSrc = 1'b1;
            end
            S_MEMWRITE: begin
                mreq   = 1'b1;
                AdrSrc = 1'b1;
                mw     = cond_ex;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                rg_w      = cond_ex;
                pc_w      = cond_ex && rd_pc;
            end
            S_EXECR: begin
                ALUControl = alu_op;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_op;
            end
            S_ALUWB: begin
                rg_w = cond_ex;
                pc_w = cond_ex && rd_pc;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_w      = cond_ex;
            end
            default: ;
        endcase
    end

    // enables are forced low while reset is held so an abandoned
    // access cannot strobe anything
    assign mem_req  = mreq && reset;
    assign PCWrite  = pc_w && reset;
    assign IRWrite  = ir_w && reset;
    assign RegWrite = rg_w && reset;
    assign MemWrite = mw && reset;

    assign ImmSrc      = op;
    assign RegSrc      = {op == 2'b01, op == 2'b10};
    assign state_dbg   = state_q;
    assign timeout_err = terr_q;
    assign illegal_op  = (state_q == S_DECODE) && (op == 2'b11);

endmodule

// File: tb/tb_arm_mc_controller.sv
// Bench for arm_mc_controller: fixed instruction table, hand sequences for
// wait/timeout/reset/branch cases, and randomized runs against a model.
`timescale 1ns/1ps
module tb_arm_mc_controller;

    localparam int TO = 4;

    localparam logic [3:0] PH_FETCH    = 4'd0;
    localparam logic [3:0] PH_DECODE   = 4'd1;
    localparam logic [3:0] PH_MEMADR   = 4'd2;
    localparam logic [3:0] PH_MEMREAD  = 4'd3;
    localparam logic [3:0] PH_MEMWB    = 4'd4;
    localparam logic [3:0] PH_MEMWRITE = 4'd5;
    localparam logic [3:0] PH_EXECR    = 4'd6;
    localparam logic [3:0] PH_EXECI    = 4'd7;
    localparam logic [3:0] PH_ALUWB    = 4'd8;
    localparam logic [3:0] PH_BRANCH   = 4'd9;
    localparam logic [3:0] PH_FAULT    = 4'd15;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        mem_ready;
    logic        mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic        ALUSrcA;
    logic [3:0]  state_dbg;
    logic        timeout_err, illegal_op;

    always #5 clk = ~clk;

    arm_mc_controller #(
        .MEM_WAIT_EN(1),
        .TIMEOUT_CYCLES(TO),
        .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .state_dbg(state_dbg), .timeout_err(timeout_err),
        .illegal_op(illegal_op)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic logic [19:0] hi(input logic [31:0] w);
        return w[31:12];
    endfunction

    // ---------------- reference model ----------------
    bit mN, mZ, mC, mV;

    // ARM style: cond[3:1] picks a base test, cond[0] inverts it
    function automatic bit cond_ok(input logic [3:0] c);
        bit b;
        case (c[3:1])
            3'd0: b = mZ;
            3'd1: b = mC;
            3'd2: b = mN;
            3'd3: b = mV;
            3'd4: b = mC && !mZ;
            3'd5: b = (mN == mV);
            3'd6: b = !mZ && (mN == mV);
            default: return !c[0];
        endcase
        return c[0] ? !b : b;
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        if (cmd == 4'd4) return 2'd0;
        if (cmd == 4'd2) return 2'd1;
        if (cmd == 4'd0) return 2'd2;
        if (cmd == 4'd12) return 2'd3;
        return 2'd0;
    endfunction

    typedef struct packed {
        logic       mreq, pcw, adr, mw, irw, rw;
        logic [1:0] res;
        logic       sa;
        logic [1:0] sb, alu, imm, rsrc;
        logic       ill, terr;
    } ctl_t;

    function automatic void expect_ctl(input logic [3:0] ph, input bit rdy,
                                       input logic [31:0] iw,
                                       output ctl_t e, output ctl_t m);
        logic [1:0] op;
        bit cx, r15;
        op  = iw[27:26];
        cx  = cond_ok(iw[31:28]);
        r15 = (iw[15:12] == 4'hF);
        e = '0;
        m = '0;
        m.mreq = 1; m.pcw = 1; m.mw = 1; m.irw = 1; m.rw = 1;
        m.imm = 2'b11; m.rsrc = 2'b11; m.ill = 1; m.terr = 1;
        e.imm  = op;
        e.rsrc = {op == 2'b01, op == 2'b10};
        e.terr = (ph == PH_FAULT);
        case (ph)
            PH_FETCH: begin
                e.mreq = 1; e.irw = rdy; e.pcw = rdy;
                m.adr = 1; e.adr = 0; m.sa = 1; e.sa = 1;
                m.sb = 2'b11; e.sb = 2'b10; m.alu = 2'b11; e.alu = 2'b00;
                m.res = 2'b11; e.res = 2'b10;
            end
            PH_DECODE: begin
                m.sa = 1; e.sa = 1; m.sb = 2'b11; e.sb = 2'b10;
                m.res = 2'b11; e.res = 2'b10; e.ill = (op == 2'b11);
            end
            PH_MEMADR: begin
                m.sa = 1; e.sa = 0; m.sb = 2'b11; e.sb = 2'b01;
                m.alu = 2'b11; e.alu = 2'b00;
            end
            PH_MEMREAD, PH_MEMWRITE: begin
                e.mreq = 1; m.adr = 1; e.adr = 1;
                m.res = 2'b11; e.res = 2'b00;
                e.mw = (ph == PH_MEMWRITE) && cx;
            end
            PH_MEMWB, PH_ALUWB: begin
                m.res = 2'b11;
                e.res = (ph == PH_MEMWB) ? 2'b01 : 2'b00;
                e.rw = cx; e.pcw = cx && r15;
            end
            PH_EXECR, PH_EXECI: begin
                m.sb = 2'b11; e.sb = (ph == PH_EXECI) ? 2'b01 : 2'b00;
                m.alu = 2'b11; e.alu = alu_of(iw[24:21]);
            end
            PH_BRANCH: begin
                m.sa = 1; e.sa = 0; m.sb = 2'b11; e.sb = 2'b01;
                m.alu = 2'b11; e.alu = 2'b00;
                m.res = 2'b11; e.res = 2'b10; e.pcw = cx;
            end
            default: ;
        endcase
    endfunction

    // ---------------- drivers (called at a falling edge) ----------------
    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("rst_state", 32'(state_dbg), 32'(PH_FETCH));
        chk("rst_enables",
            32'({mem_req, PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mN = 0; mZ = 0; mC = 0; mV = 0;
    endtask

    task automatic drive(input bit rdy, input logic [3:0] fl);
        mem_ready = rdy;
        ALUFlags = fl;
        #1;
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic cyc(input logic [3:0] ph, input logic [31:0] iw,
                       input bit rdy);
        ctl_t e, m, a;
        logic [3:0] fl;
        fl = 4'($urandom);
        drive(rdy, fl);
        a = {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc,
             illegal_op, timeout_err};
        expect_ctl(ph, rdy, iw, e, m);
        chk("rnd_state", 32'(state_dbg), 32'(ph));
        chk("rnd_ctl", 32'(a & m), 32'(e & m));
        if ((ph == PH_EXECR || ph == PH_EXECI) && iw[20]
            && cond_ok(iw[31:28])) begin
            mN = fl[3];
            mZ = fl[2];
            if (alu_of(iw[24:21]) < 2'd2) begin
                mC = fl[1];
                mV = fl[0];
            end
        end
        adv();
    endtask

    // TO consecutive waits end in FAULT
    task automatic mem_wait(input logic [3:0] ph, input logic [31:0] iw,
                            output bit flt);
        int w;
        w = ($urandom_range(0, 11) == 0) ? TO : int'($urandom_range(0, TO - 1));
        flt = 0;
        for (int i = 0; i < w; i++) cyc(ph, iw, 1'b0);
        if (w >= TO) flt = 1;
        else cyc(ph, iw, 1'b1);
    endtask

    task automatic fault_recover(input logic [31:0] iw);
        for (int i = 0; i < 3; i++) cyc(PH_FAULT, iw, 1'($urandom));
        do_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [3:0] c, rd;
        logic [1:0] op;
        int r;
        c = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
        r = $urandom_range(0, 9);
        op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
        return {c, op, 6'($urandom), 4'($urandom), rd, 12'($urandom)};
    endfunction

    task automatic run_random(input int nins);
        logic [31:0] iw;
        bit flt;
        for (int n = 0; n < nins; n++) begin
            iw = rand_instr();
            Instr = hi(iw);
            mem_wait(PH_FETCH, iw, flt);
            if (flt) begin
                fault_recover(iw);
                continue;
            end
            cyc(PH_DECODE, iw, 1'($urandom));
            case (iw[27:26])
                2'b00: begin
                    cyc(iw[25] ? PH_EXECI : PH_EXECR, iw, 1'($urandom));
                    cyc(PH_ALUWB, iw, 1'($urandom));
                end
                2'b01: begin
                    cyc(PH_MEMADR, iw, 1'($urandom));
                    if (iw[20]) begin
                        mem_wait(PH_MEMREAD, iw, flt);
                        if (flt) fault_recover(iw);
                        else cyc(PH_MEMWB, iw, 1'($urandom));
                    end else begin
                        mem_wait(PH_MEMWRITE, iw, flt);
                        if (flt) fault_recover(iw);
                    end
                end
                2'b10: cyc(PH_BRANCH, iw, 1'($urandom));
                default: ;
            endcase
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [31:0] w;
        logic [23:0] seq;
        int          n;
        logic [1:0]  alu;
        logic [1:0]  rsrc;
        bit          rw;
    } vec_t;

    vec_t vt[10];

    initial begin
        int cnt;
        vt[0] = '{32'hE2821005, 24'h017800, 5, 2'd0, 2'b00, 1'b1};
        vt[1] = '{32'hE0443005, 24'h016800, 5, 2'd1, 2'b00, 1'b1};
        vt[2] = '{32'hE2012001, 24'h017800, 5, 2'd2, 2'b00, 1'b1};
        vt[3] = '{32'hE1812003, 24'h016800, 5, 2'd3, 2'b00, 1'b1};
        vt[4] = '{32'hE0212003, 24'h016800, 5, 2'd0, 2'b00, 1'b1};
        vt[5] = '{32'hE5912000, 24'h012340, 6, 2'd0, 2'b10, 1'b1};
        vt[6] = '{32'hE5812000, 24'h012500, 5, 2'd0, 2'b10, 1'b0};
        vt[7] = '{32'hEA000001, 24'h019000, 4, 2'd0, 2'b01, 1'b0};
        vt[8] = '{32'hEC000000, 24'h010000, 3, 2'd0, 2'b00, 1'b0};
        vt[9] = '{32'h02821005, 24'h017800, 5, 2'd0, 2'b00, 1'b0};

        reset = 1'b0;
        Instr = '0;
        mem_ready = 1'b0;
        ALUFlags = 4'b0000;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            do_reset();
            Instr = hi(vt[v].w);
            for (int k = 0; k < vt[v].n; k++) begin
                logic [3:0] es;
                es = vt[v].seq[23 - 4 * k -: 4];
                drive(1'b1, 4'b0000);
                chk($sformatf("vec%0d_state%0d", v, k), 32'(state_dbg), 32'(es));
                chk($sformatf("vec%0d_regsrc", v), 32'(RegSrc),
                    32'(vt[v].rsrc));
                chk($sformatf("vec%0d_regwrite%0d", v, k), 32'(RegWrite),
                    32'(vt[v].rw && (es == PH_MEMWB || es == PH_ALUWB)));
                if (es == PH_EXECR || es == PH_EXECI)
                    chk($sformatf("vec%0d_aluctl", v), 32'(ALUControl),
                        32'(vt[v].alu));
                adv();
            end
        end

        // LDR with three wait cycles in MEMREAD
        do_reset();
        Instr = hi(32'hE5912000);
        drive(1, 0); adv();
        drive(1, 0); adv();
        drive(1, 0); adv();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, 0);
            if (mem_req && state_dbg == PH_MEMREAD) cnt++;
            adv();
        end
        chk("ldr_req_cycles", 32'(cnt), 32'd4);
        drive(1, 0);
        chk("ldr_memwb", 32'(state_dbg), 32'(PH_MEMWB));
        chk("ldr_no_timeout", 32'(timeout_err), 32'd0);
        chk("ldr_regwrite", 32'(RegWrite), 32'd1);
        adv();
        drive(1, 0);
        chk("ldr_back_fetch", 32'(state_dbg), 32'(PH_FETCH));
        adv();

        // fetch timeout
        do_reset();
        Instr = hi(32'hE2821005);
        for (int k = 1; k <= TO; k++) begin
            drive(0, 0);
            chk($sformatf("to_wait%0d", k), 32'(state_dbg), 32'(PH_FETCH));
            adv();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'($urandom), 0);
            chk("to_fault_state", 32'(state_dbg), 32'(PH_FAULT));
            chk("to_terr", 32'(timeout_err), 32'd1);
            chk("to_enables",
                32'({mem_req, PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
            adv();
        end

        // SUBS to zero, then BEQ taken / not taken
        for (int t = 0; t < 2; t++) begin
            do_reset();
            Instr = hi(32'hE0511001);
            drive(1, 0); adv();
            drive(1, 0); adv();
            drive(1, (t == 0) ? 4'b0100 : 4'b0000);
            chk("subs_execr", 32'(state_dbg), 32'(PH_EXECR));
            adv();
            drive(1, 0); adv();
            Instr = hi(32'h0A000002);
            drive(1, 0); adv();
            drive(1, 0); adv();
            drive(1, 0);
            chk("beq_branch", 32'(state_dbg), 32'(PH_BRANCH));
            chk(t == 0 ? "beq_taken_pcw" : "beq_nottaken_pcw",
                32'(PCWrite), (t == 0) ? 32'd1 : 32'd0);
            adv();
        end

        // STR with reset asserted during the write wait
        do_reset();
        Instr = hi(32'hE5812000);
        drive(1, 0); adv();
        drive(1, 0); adv();
        drive(1, 0); adv();
        drive(0, 0);
        chk("str_memwrite", 32'(state_dbg), 32'(PH_MEMWRITE));
        chk("str_memw_wait", 32'(MemWrite), 32'd1);
        adv();
        drive(0, 0);
        #1 reset = 1'b0;
        #1;
        chk("str_rst_state", 32'(state_dbg), 32'(PH_FETCH));
        chk("str_rst_memw", 32'(MemWrite), 32'd0);
        chk("str_rst_req", 32'(mem_req), 32'd0);
        adv();
        reset = 1'b1;
        drive(1, 0);
        chk("str_refetch", 32'(state_dbg), 32'(PH_FETCH));
        chk("str_refetch_ir", 32'(IRWrite), 32'd1);
        adv();
        drive(1, 0);
        chk("str_decode", 32'(state_dbg), 32'(PH_DECODE));
        adv();

        // op=11 illegal
        do_reset();
        Instr = hi(32'hEC000000);
        drive(1, 0); adv();
        drive(1, 0);
        chk("ill_pulse", 32'(illegal_op), 32'd1);
        chk("ill_wr", 32'({RegWrite, MemWrite}), 32'd0);
        adv();
        drive(1, 0);
        chk("ill_next", 32'(state_dbg), 32'(PH_FETCH));
        chk("ill_clear", 32'(illegal_op), 32'd0);
        chk("ill_wr2", 32'({RegWrite, MemWrite}), 32'd0);
        adv();

        do_reset();
        run_random(150);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
